multi_ch_freq_divider: RTL and testbench

- Parametrised, multi-channel programmable clock divider. Successor to the single-channel divider used in the multiplexed counter block.
- Each channel generates a registered, glitch-free divided output with programmable period, high time and phase. All channels can be re-aligned by a common sync pulse.
- Configuration changes apply only at period boundaries, so outputs never produce runt pulses.
- Outputs feed the event-clock and counter logic as clock enables or strobes.

---
 rtl/multi_ch_freq_divider.sv | 98 +++++++++
 tb/tb_multi_ch_freq_divider.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_freq_divider.sv
// Multi-channel programmable clock divider: per-channel period, high time and phase,
// with config taken only at period boundaries and a shared re-phasing sync pulse.
module multi_ch_freq_divider #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    sync,
  input  logic [NUM_CH*WIDTH-1:0] divide_data,
  input  logic [NUM_CH*WIDTH-1:0] high_data,
  input  logic [NUM_CH*WIDTH-1:0] phase_data,
  output logic [NUM_CH-1:0]       clkout,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       cfg_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] div_in, high_in, phase_in;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] div_act_q, div_act_d;
      logic [WIDTH-1:0] high_act_q, high_act_d;
      logic             run_q, run_d;
      logic             clkout_q, clkout_d;
      logic             tick_q, tick_d;
      logic             cfg_err_q, cfg_err_d;
      logic             idle;

      assign div_in   = divide_data[gi*WIDTH +: WIDTH];
      assign high_in  = high_data[gi*WIDTH +: WIDTH];
      assign phase_in = phase_data[gi*WIDTH +: WIDTH];

      always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        high_act_d = high_act_q;
        run_d      = run_q;
        idle       = !ch_en[gi] || (div_in < TWO);
        cfg_err_d  = ch_en[gi] && (div_in < TWO);

        if (idle) begin
          cnt_d      = '0;
          div_act_d  = div_in;
          high_act_d = high_in;
          run_d      = 1'b0;
        end else if (sync) begin
          // Sync outranks both a pending wrap and a fresh start.
          div_act_d  = div_in;
          high_act_d = high_in;
          cnt_d      = (phase_in < div_in) ? phase_in : '0;
          run_d      = 1'b1;
        end else if (!run_q || (cnt_q == div_act_q - ONE)) begin
          cnt_d      = '0;
          div_act_d  = div_in;
          high_act_d = high_in;
          run_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end

        // cnt is 0 only on the first cycle of a period, so that alone marks a tick.
        clkout_d = run_d && (cnt_d < high_act_d);
        tick_d   = run_d && (cnt_d == '0);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q      <= '0;
          div_act_q  <= '0;
          high_act_q <= '0;
          run_q      <= 1'b0;
          clkout_q   <= 1'b0;
          tick_q     <= 1'b0;
          cfg_err_q  <= 1'b0;
        end else begin
          cnt_q      <= cnt_d;
          div_act_q  <= div_act_d;
          high_act_q <= high_act_d;
          run_q      <= run_d;
          clkout_q   <= clkout_d;
          tick_q     <= tick_d;
          cfg_err_q  <= cfg_err_d;
        end
      end

      assign clkout[gi]  = clkout_q;
      assign tick[gi]    = tick_q;
      assign cfg_err[gi] = cfg_err_q;
    end
  endgenerate

endmodule

// File: tb/tb_multi_ch_freq_divider.sv
// Scoreboard bench for multi_ch_freq_divider: stimulus queues the expected per-cycle
// outputs of all four channels, a monitor pops and compares after each clock edge.
module tb_multi_ch_freq_divider;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       ch_en;
  logic                    sync;
  logic [NUM_CH*WIDTH-1:0] divide_data;
  logic [NUM_CH*WIDTH-1:0] high_data;
  logic [NUM_CH*WIDTH-1:0] phase_data;
  logic [NUM_CH-1:0]       clkout;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [3:0] c;
    logic [3:0] t;
    logic [3:0] e;
  } exp_t;

  exp_t exp_q[$];

  multi_ch_freq_divider #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_en       (ch_en),
    .sync        (sync),
    .divide_data (divide_data),
    .high_data   (high_data),
    .phase_data  (phase_data),
    .clkout      (clkout),
    .tick        (tick),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endfunction

  // Monitor: every edge with a queued expectation is one transaction.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        $display("%0t %s clkout=%b tick=%b cfg_err=%b", $time, x.nm, clkout, tick, cfg_err);
        chk({x.nm, ".clkout"}, clkout, x.c);
        chk({x.nm, ".tick"}, tick, x.t);
        chk({x.nm, ".cfg_err"}, cfg_err, x.e);
      end
    end
  end

  // Expected outputs after the next rising edge; inputs may change on return.
  task automatic ex(string nm, logic [3:0] c, logic [3:0] t, logic [3:0] e);
    exp_t x;
    @(posedge clk);
    x.nm = nm;
    x.c  = c;
    x.t  = t;
    x.e  = e;
    exp_q.push_back(x);
    #2;
  endtask

  task automatic set_ch(int ch, logic [31:0] d, logic [31:0] h, logic [31:0] p);
    divide_data[ch*WIDTH +: WIDTH] = d;
    high_data[ch*WIDTH +: WIDTH]   = h;
    phase_data[ch*WIDTH +: WIDTH]  = p;
  endtask

  initial begin
    rst         = 1'b0;
    ch_en       = '0;
    sync        = 1'b0;
    divide_data = '0;
    high_data   = '0;
    phase_data  = '0;
    ex("reset0", 4'b0000, 4'b0000, 4'b0000);
    ex("reset1", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;

    // divide 4, high 2 on ch0; ch1 enabled with divide 1 flags cfg_err
    set_ch(0, 4, 2, 0);
    set_ch(1, 1, 0, 0);
    ch_en = 4'b0011;
    ex("d4h2_c0", 4'b0001, 4'b0001, 4'b0010);
    ex("d4h2_c1", 4'b0001, 4'b0000, 4'b0010);
    ex("d4h2_c2", 4'b0000, 4'b0000, 4'b0010);
    ex("d4h2_c3", 4'b0000, 4'b0000, 4'b0010);
    ex("d4h2_c0b", 4'b0001, 4'b0001, 4'b0010);
    // async reset mid-period while clkout, tick and cfg_err are all set
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst.clkout", clkout, 4'b0000);
    chk("async_rst.tick", tick, 4'b0000);
    chk("async_rst.cfg_err", cfg_err, 4'b0000);
    ch_en = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    ex("post_rst", 4'b0000, 4'b0000, 4'b0000);

    // divide 5 high 2, then 3/1 requested mid-period: applies only at wrap
    set_ch(1, 0, 0, 0);
    set_ch(0, 5, 2, 0);
    ch_en = 4'b0001;
    ex("d5_0", 4'b0001, 4'b0001, 4'b0000);
    ex("d5_1", 4'b0001, 4'b0000, 4'b0000);
    ex("d5_2", 4'b0000, 4'b0000, 4'b0000);
    set_ch(0, 3, 1, 0);
    ex("d5_3", 4'b0000, 4'b0000, 4'b0000);
    ex("d5_4", 4'b0000, 4'b0000, 4'b0000);
    ex("d3_0", 4'b0001, 4'b0001, 4'b0000);
    ex("d3_1", 4'b0000, 4'b0000, 4'b0000);
    ex("d3_2", 4'b0000, 4'b0000, 4'b0000);
    ex("d3_0b", 4'b0001, 4'b0001, 4'b0000);
    ex("d3_1b", 4'b0000, 4'b0000, 4'b0000);

    // divide 1 and 0 are errors and idle the channel; divide 6 restarts
    set_ch(0, 1, 0, 0);
    ex("div1_a", 4'b0000, 4'b0000, 4'b0001);
    ex("div1_b", 4'b0000, 4'b0000, 4'b0001);
    set_ch(0, 0, 0, 0);
    ex("div0", 4'b0000, 4'b0000, 4'b0001);
    set_ch(0, 6, 3, 0);
    ex("div6_0", 4'b0001, 4'b0001, 4'b0000);
    ex("div6_1", 4'b0001, 4'b0000, 4'b0000);

    // four channels divide 8 high 4, phases 0/2/4/6
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 8, 4, 2 * i);
    ch_en = 4'b1111;
    sync  = 1'b1;
    ex("ph_1", 4'b0011, 4'b0001, 4'b0000);
    sync = 1'b0;
    ex("ph_2", 4'b0011, 4'b0000, 4'b0000);
    ex("ph_3", 4'b1001, 4'b1000, 4'b0000);
    ex("ph_4", 4'b1001, 4'b0000, 4'b0000);
    ex("ph_5", 4'b1100, 4'b0100, 4'b0000);
    ex("ph_6", 4'b1100, 4'b0000, 4'b0000);
    ex("ph_7", 4'b0110, 4'b0010, 4'b0000);
    ex("ph_8", 4'b0110, 4'b0000, 4'b0000);
    ex("ph_9", 4'b0011, 4'b0001, 4'b0000);
    set_ch(3, 8, 4, 9);
    sync = 1'b1;
    ex("ph9_a", 4'b1011, 4'b1001, 4'b0000);
    sync = 1'b0;
    ex("ph9_b", 4'b1011, 4'b0000, 4'b0000);

    // corners: ch0 high 0 (never high, still ticks), ch1 high = divide = 7
    ch_en = '0;
    ex("idle_a", 4'b0000, 4'b0000, 4'b0000);
    set_ch(0, 4, 0, 0);
    set_ch(1, 7, 7, 0);
    ch_en = 4'b0011;
    ex("cor_1", 4'b0010, 4'b0011, 4'b0000);
    ex("cor_2", 4'b0010, 4'b0000, 4'b0000);
    ex("cor_3", 4'b0010, 4'b0000, 4'b0000);
    ex("cor_4", 4'b0010, 4'b0000, 4'b0000);
    ex("cor_5", 4'b0010, 4'b0001, 4'b0000);
    ex("cor_6", 4'b0010, 4'b0000, 4'b0000);
    ex("cor_7", 4'b0010, 4'b0000, 4'b0000);
    ex("cor_8", 4'b0010, 4'b0010, 4'b0000);
    ex("cor_9", 4'b0010, 4'b0001, 4'b0000);

    // sync at a wrap, ch1 enabled with the sync, ch2 disabled, then ch0 dropped
    ch_en = '0;
    ex("idle_b", 4'b0000, 4'b0000, 4'b0000);
    set_ch(0, 4, 2, 2);
    set_ch(1, 6, 3, 4);
    set_ch(2, 5, 2, 1);
    set_ch(3, 8, 4, 0);
    ch_en = 4'b0001;
    ex("sw_1", 4'b0001, 4'b0001, 4'b0000);
    ex("sw_2", 4'b0001, 4'b0000, 4'b0000);
    ex("sw_3", 4'b0000, 4'b0000, 4'b0000);
    ex("sw_4", 4'b0000, 4'b0000, 4'b0000);
    sync  = 1'b1;
    ch_en = 4'b0011;
    ex("sw_sync", 4'b0000, 4'b0000, 4'b0000);
    sync = 1'b0;
    ex("sw_6", 4'b0000, 4'b0000, 4'b0000);
    ex("sw_7", 4'b0011, 4'b0011, 4'b0000);
    ex("sw_8", 4'b0011, 4'b0000, 4'b0000);
    ch_en = 4'b0010;
    ex("en_fall", 4'b0010, 4'b0000, 4'b0000);

    // divide 2^32-1 with the counter preloaded near the top
    ch_en = '0;
    ex("idle_c", 4'b0000, 4'b0000, 4'b0000);
    set_ch(0, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFC);
    ch_en = 4'b0001;
    sync  = 1'b1;
    ex("big_1", 4'b0000, 4'b0000, 4'b0000);
    sync = 1'b0;
    ex("big_2", 4'b0000, 4'b0000, 4'b0000);
    ex("big_3", 4'b0000, 4'b0000, 4'b0000);
    ex("big_wrap", 4'b0001, 4'b0001, 4'b0000);
    ex("big_5", 4'b0001, 4'b0000, 4'b0000);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
